cheshire_uart_dbg_target: RTL and testbench

SoC-side responder for the UART debug preload protocol: consumes the byte stream from the UART receiver, decodes single-word read/write command frames, and issues them as OBI-style memory requests. It returns acknowledge or read-data bytes to the UART transmitter. It sits between the UART RX/TX byte streams and a crossbar manager port, and lets the host load ELFs and poll the exit code over UART.

---
 rtl/cheshire_uart_dbg_pkg.sv | 27 ++
 rtl/cheshire_uart_dbg_target_ser.sv | 38 +++
 rtl/cheshire_uart_dbg_target.sv | 152 +++++++++++++++
 tb/tb_cheshire_uart_dbg_target.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cheshire_uart_dbg_pkg.sv
// Shared opcodes, response bytes and FSM encoding for the UART debug preload target.
package cheshire_uart_dbg_pkg;

  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_READ  = 8'h02;
  localparam logic [7:0] OP_PING  = 8'h03;

  localparam logic [7:0] RSP_ACK  = 8'hA5;
  localparam logic [7:0] RSP_ERR  = 8'hEE;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ADDR   = 3'd1;
  localparam logic [2:0] ST_WDATA  = 3'd2;
  localparam logic [2:0] ST_REQ    = 3'd3;
  localparam logic [2:0] ST_WAIT_R = 3'd4;
  localparam logic [2:0] ST_RESP   = 3'd5;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    ADDR   = ST_ADDR,
    WDATA  = ST_WDATA,
    REQ    = ST_REQ,
    WAIT_R = ST_WAIT_R,
    RESP   = ST_RESP
  } uart_dbg_state_e;

endpackage

// File: rtl/cheshire_uart_dbg_target_ser.sv
// Response serializer: loads a word plus byte count, emits it LSB first, one byte per handshake.
// First byte valid the cycle after load; tx_data holds while valid and not ready.
module cheshire_uart_dbg_target_ser #(
  parameter int unsigned NumBytes = 4,
  parameter int unsigned LenW     = $clog2(NumBytes + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [8*NumBytes-1:0] word,
  input  logic [LenW-1:0]       len,
  output logic                  valid,
  output logic [7:0]            data,
  input  logic                  ready,
  output logic                  last
);

  logic [8*NumBytes-1:0] sreg;
  logic [LenW-1:0]       left;

  assign valid = (left != '0);
  assign data  = sreg[7:0];
  assign last  = valid && ready && (left == LenW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg <= '0;
      left <= '0;
    end else if (load) begin
      sreg <= word;
      left <= len;
    end else if (valid && ready) begin
      sreg <= sreg >> 8;
      left <= left - LenW'(1);
    end
  end

endmodule

// File: rtl/cheshire_uart_dbg_target.sv
// UART debug target: decodes read/write/ping frames into single OBI requests and answers over TX.
// Request rises 1 cycle after the last frame byte; CHESHIRE_UART_DBG_TIMEOUT_EN enables the partial-frame timeout.
module cheshire_uart_dbg_target #(
  parameter int unsigned AddrBytes     = 4,
  parameter int unsigned DataBytes     = 4,
  parameter int unsigned TimeoutCycles = 65536
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   rx_valid_i,
  input  logic [7:0]             rx_data_i,
  output logic                   rx_ready_o,
  output logic                   tx_valid_o,
  output logic [7:0]             tx_data_o,
  input  logic                   tx_ready_i,
  output logic                   mem_req_o,
  input  logic                   mem_gnt_i,
  output logic                   mem_we_o,
  output logic [8*AddrBytes-1:0] mem_addr_o,
  output logic [8*DataBytes-1:0] mem_wdata_o,
  output logic [DataBytes-1:0]   mem_be_o,
  input  logic                   mem_rvalid_i,
  input  logic [8*DataBytes-1:0] mem_rdata_i,
  input  logic                   mem_err_i,
  output logic                   busy_o
);

  import cheshire_uart_dbg_pkg::*;

  localparam int unsigned MaxBytes = (AddrBytes > DataBytes) ? AddrBytes : DataBytes;
  localparam int unsigned CntW     = $clog2(MaxBytes + 1);
  localparam int unsigned LenW     = $clog2(DataBytes + 1);
  localparam logic [CntW-1:0] AddrLast = CntW'(AddrBytes - 1);
  localparam logic [CntW-1:0] DataLast = CntW'(DataBytes - 1);

  uart_dbg_state_e state, state_d;
  logic [CntW-1:0] cnt;
  logic            rx_hs;
  logic            timeout;

  logic                  ser_load;
  logic [8*DataBytes-1:0] ser_word;
  logic [LenW-1:0]       ser_len;
  logic                  ser_last;

  assign rx_ready_o = (state == IDLE) || (state == ADDR) || (state == WDATA);
  assign rx_hs      = rx_valid_i && rx_ready_o;
  assign mem_req_o  = (state == REQ);
  assign mem_be_o   = '1;
  assign busy_o     = (state != IDLE);

  always_comb begin
    state_d  = state;
    ser_load = 1'b0;
    ser_word = '0;
    ser_len  = LenW'(1);
    unique case (state)
      IDLE: begin
        if (rx_hs) begin
          if (rx_data_i == OP_WRITE || rx_data_i == OP_READ) begin
            state_d = ADDR;
          end else begin
            state_d       = RESP;
            ser_load      = 1'b1;
            ser_word[7:0] = (rx_data_i == OP_PING) ? RSP_ACK : RSP_ERR;
          end
        end
      end
      ADDR: begin
        if (rx_hs && cnt == AddrLast) state_d = mem_we_o ? WDATA : REQ;
      end
      WDATA: begin
        if (rx_hs && cnt == DataLast) state_d = REQ;
      end
      REQ: begin
        if (mem_gnt_i) state_d = WAIT_R;
      end
      WAIT_R: begin
        if (mem_rvalid_i) begin
          state_d  = RESP;
          ser_load = 1'b1;
          if (mem_err_i) begin
            ser_word[7:0] = RSP_ERR;
          end else if (mem_we_o) begin
            ser_word[7:0] = RSP_ACK;
          end else begin
            ser_word = mem_rdata_i;
            ser_len  = LenW'(DataBytes);
          end
        end
      end
      RESP: begin
        if (ser_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (timeout) state_d = IDLE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else begin
      state <= state_d;
      if (state_d != state) cnt <= '0;
      else if (rx_hs)       cnt <= cnt + CntW'(1);
      if (state == IDLE && rx_hs) mem_we_o <= (rx_data_i == OP_WRITE);
      if (state == ADDR && rx_hs)  mem_addr_o[8*int'(cnt) +: 8]  <= rx_data_i;
      if (state == WDATA && rx_hs) mem_wdata_o[8*int'(cnt) +: 8] <= rx_data_i;
    end
  end

`ifdef CHESHIRE_UART_DBG_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TimeoutCycles + 1);
  logic [ToW-1:0] to_cnt;
  logic           in_frame;

  assign in_frame = (state == ADDR) || (state == WDATA);
  // Fires on the cycle the gap counter would reach TimeoutCycles.
  assign timeout  = in_frame && !rx_hs && (to_cnt == ToW'(TimeoutCycles - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                           to_cnt <= '0;
    else if (!in_frame || rx_hs || timeout) to_cnt <= '0;
    else                                 to_cnt <= to_cnt + ToW'(1);
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TimeoutCycles;
  assign timeout = 1'b0;
`endif

  cheshire_uart_dbg_target_ser #(
    .NumBytes (DataBytes),
    .LenW     (LenW)
  ) i_ser (
    .clk   (clk_i),
    .rst   (rst_i),
    .load  (ser_load),
    .word  (ser_word),
    .len   (ser_len),
    .valid (tx_valid_o),
    .data  (tx_data_o),
    .ready (tx_ready_i),
    .last  (ser_last)
  );

endmodule

// File: tb/tb_cheshire_uart_dbg_target.sv
// Scoreboard bench for cheshire_uart_dbg_target: directed frames, expected TX bytes and requests queued at issue.
module tb_cheshire_uart_dbg_target;

  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_READ  = 8'h02;
  localparam logic [7:0] OP_PING  = 8'h03;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid, rx_ready, tx_valid, tx_ready;
  logic [7:0]  rx_data, tx_data;
  logic        mem_req, mem_gnt, mem_we, mem_rvalid, mem_err, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  logic [7:0]  exp_tx[$];
  req_t        exp_req[$];
  logic [31:0] mem_model [logic [31:0]];

  int checks = 0;
  int errors = 0;
  int gnt_delay = 0;
  int cyc = 0;
  logic bp_mode = 1'b0;
  logic err_next = 1'b0;
  logic rsp_drop = 1'b0;
  logic gnt_seen = 1'b0;
  logic held = 1'b0;
  logic [7:0] held_dat = 8'h00;

  always #5 clk = ~clk;

  cheshire_uart_dbg_target #(
    .AddrBytes     (4),
    .DataBytes     (4),
    .TimeoutCycles (100)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .rx_valid_i   (rx_valid),
    .rx_data_i    (rx_data),
    .rx_ready_o   (rx_ready),
    .tx_valid_o   (tx_valid),
    .tx_data_o    (tx_data),
    .tx_ready_i   (tx_ready),
    .mem_req_o    (mem_req),
    .mem_gnt_i    (mem_gnt),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_be_o     (mem_be),
    .mem_rvalid_i (mem_rvalid),
    .mem_rdata_i  (mem_rdata),
    .mem_err_i    (mem_err),
    .busy_o       (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_reset_state();
    check("rst_rx_ready", 32'(rx_ready), 32'd1);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_mem_be", 32'(mem_be), 32'hF);
    check("rst_busy", 32'(busy), 32'd0);
  endtask

  // Caller is at posedge+1; returns at posedge+1 after the handshake edge.
  task automatic send_byte(input logic [7:0] b);
    int   n;
    logic ok;
    n  = 0;
    ok = 1'b0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (!ok && n < 1000) begin
      @(negedge clk);
      ok = rx_ready;
      @(posedge clk);
      #1;
      n++;
    end
    rx_valid = 1'b0;
    if (!ok) check("rx_accept_timeout", 32'(ok), 32'd1);
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] wdata);
    req_t r;
    if (op == OP_WRITE || op == OP_READ) begin
      r.we = (op == OP_WRITE);
      r.addr = addr;
      r.wdata = wdata;
      exp_req.push_back(r);
    end
    send_byte(op);
    if (op == OP_WRITE || op == OP_READ)
      for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8]);
    if (op == OP_WRITE)
      for (int i = 0; i < 4; i++) send_byte(wdata[8*i +: 8]);
  endtask

  task automatic push_tx4(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
    exp_tx.push_back(b0);
    exp_tx.push_back(b1);
    exp_tx.push_back(b2);
    exp_tx.push_back(b3);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((exp_tx.size() != 0 || exp_req.size() != 0) && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, 32'(n < 3000), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  // TX monitor: pops one expected byte per handshake and checks hold under backpressure.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 1'b0;
      end else begin
        if (held) begin
          check("tx_hold_valid", 32'(tx_valid), 32'd1);
          check("tx_hold_data", 32'(tx_data), 32'(held_dat));
        end
        if (tx_valid && tx_ready) begin
          if (exp_tx.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL tx_unexpected: got byte %h, expected no byte", tx_data);
          end else begin
            check("tx_byte", 32'(tx_data), 32'(exp_tx.pop_front()));
          end
        end
        held = tx_valid && !tx_ready;
        held_dat = tx_data;
      end
    end
  end

  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      tx_ready = !bp_mode || (cyc % 4 == 0);
    end
  end

  // Memory responder: checks each request against the queue, then grants and responds.
  initial begin
    req_t got, e;
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = 32'h0;
    mem_err = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && mem_req) begin
        got.we = mem_we;
        got.addr = mem_addr;
        got.wdata = mem_wdata;
        check("req_be", 32'(mem_be), 32'hF);
        if (exp_req.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL req_unexpected: got request to %h, expected none", mem_addr);
        end else begin
          e = exp_req.pop_front();
          check("req_we", 32'(got.we), 32'(e.we));
          check("req_addr", got.addr, e.addr);
          if (e.we) check("req_wdata", got.wdata, e.wdata);
        end
        for (int i = 0; i < gnt_delay; i++) begin
          @(negedge clk);
          check("req_held", 32'(mem_req), 32'd1);
          check("req_addr_stable", mem_addr, got.addr);
          check("req_wdata_stable", mem_wdata, got.wdata);
          check("req_we_stable", 32'(mem_we), 32'(got.we));
        end
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        check("req_released", 32'(mem_req), 32'd0);
        if (!rsp_drop) begin
          mem_rvalid = 1'b1;
          mem_err = err_next;
          mem_rdata = 32'h0;
          if (!got.we && !err_next && mem_model.exists(got.addr)) mem_rdata = mem_model[got.addr];
          if (got.we && !err_next) mem_model[got.addr] = got.wdata;
          err_next = 1'b0;
          @(negedge clk);
          mem_rvalid = 1'b0;
          mem_err = 1'b0;
        end
        gnt_seen = 1'b1;
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    #1;
    check_reset_state();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    exp_tx.push_back(8'hA5);
    send_frame(OP_WRITE, 32'h8000_0000, 32'hDEAD_BEEF);
    wait_done("drain_write");
    push_tx4(8'hEF, 8'hBE, 8'hAD, 8'hDE);
    send_frame(OP_READ, 32'h8000_0000, 32'h0);
    wait_done("drain_read");

    exp_tx.push_back(8'hA5);
    send_frame(OP_PING, 32'h0, 32'h0);
    wait_done("drain_ping");

    gnt_delay = 5;
    bp_mode = 1'b1;
    exp_tx.push_back(8'hA5);
    send_frame(OP_WRITE, 32'h8000_0004, 32'h1234_5678);
    wait_done("drain_bp_write");
    push_tx4(8'h78, 8'h56, 8'h34, 8'h12);
    send_frame(OP_READ, 32'h8000_0004, 32'h0);
    wait_done("drain_bp_read");
    gnt_delay = 0;
    bp_mode = 1'b0;

    err_next = 1'b1;
    exp_tx.push_back(8'hEE);
    send_frame(OP_READ, 32'h8000_0000, 32'h0);
    wait_done("drain_err");

    exp_tx.push_back(8'hEE);
    send_frame(8'h7F, 32'h0, 32'h0);
    push_tx4(8'hEF, 8'hBE, 8'hAD, 8'hDE);
    send_frame(OP_READ, 32'h8000_0000, 32'h0);
    wait_done("drain_illegal");

    send_byte(OP_READ);
    send_byte(8'h00);
    send_byte(8'h00);
    repeat (99) @(posedge clk);
    #1;
    check("gap99_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
`ifdef CHESHIRE_UART_DBG_TIMEOUT_EN
    check("gap100_timeout_idle", 32'(busy), 32'd0);
    repeat (10) @(posedge clk);
    #1;
    push_tx4(8'h78, 8'h56, 8'h34, 8'h12);
    send_frame(OP_READ, 32'h8000_0004, 32'h0);
`else
    check("gap100_still_addr", 32'(busy), 32'd1);
    repeat (10) @(posedge clk);
    #1;
    check("gap110_still_addr", 32'(rx_ready), 32'd1);
    begin
      req_t r;
      r.we = 1'b0;
      r.addr = 32'h8000_0000;
      r.wdata = 32'h0;
      exp_req.push_back(r);
    end
    push_tx4(8'hEF, 8'hBE, 8'hAD, 8'hDE);
    send_byte(8'h00);
    send_byte(8'h80);
`endif
    wait_done("drain_after_gap");

    rsp_drop = 1'b1;
    gnt_seen = 1'b0;
    send_frame(OP_READ, 32'h8000_0008, 32'h0);
    n = 0;
    while (!gnt_seen && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("gnt_seen", 32'(gnt_seen), 32'd1);
    check("busy_wait_r", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_state();
    @(negedge clk);
    rst = 1'b0;
    rsp_drop = 1'b0;
    @(posedge clk);
    #1;
    exp_tx.push_back(8'hA5);
    send_frame(OP_PING, 32'h0, 32'h0);
    wait_done("drain_post_reset_ping");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
